// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle execute stage.
// Opcode map, FSM states and multiply step count.
package alu_pkg;

    localparam int WIDTH      = 16;
    localparam int AW         = 3;
    localparam int MUL_CYCLES = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_PSB = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    localparam logic [3:0] OP_LAST_VALID = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Sequential 16x16 shift-add multiplier, one partial product per step.
// Keeps a 32-bit accumulator so the carry flag can see the high half.
module shift_add_mul
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product_lo,
    output logic             hi_nonzero,
    output logic             last
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [4:0]         cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= 5'(MUL_CYCLES);
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 5'd1;
        end
    end

    assign product_lo = acc_q[WIDTH-1:0];
    assign hi_nonzero = |acc_q[2*WIDTH-1:WIDTH];
    // Asserted during the final step, so the FSM moves to WRITE right after it.
    assign last       = (cnt_q == 5'd1);

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute stage: single-cycle ALU ops, bit-serial shifts and
// a shift-add multiply, ending in a one-cycle register-file write request.
module alu_exec
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    dest,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] bus_w,
    output logic [AW-1:0]    addr_w,
    output logic             en_w,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n
);

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       op_q;
    logic [AW-1:0]    dest_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [3:0]       cnt_q;

    logic             accept;
    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;
    logic             mul_last;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c;
    logic             op_valid_q;

    assign accept     = start && (state_q == ST_IDLE);
    assign op_valid_q = (op_q <= OP_LAST_VALID);

    // Shifts load A here and then shift it in res_q during EXEC.
    always_comb begin
        sum_ext  = {1'b0, bus_a} + {1'b0, bus_b};
        diff_ext = {1'b0, bus_a} - {1'b0, bus_b};
        alu_res  = '0;
        alu_c    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
            end
            OP_AND:         alu_res = bus_a & bus_b;
            OP_OR:          alu_res = bus_a | bus_b;
            OP_XOR:         alu_res = bus_a ^ bus_b;
            OP_NOT:         alu_res = ~bus_a;
            OP_PSB:         alu_res = bus_b;
            OP_SHL, OP_SHR: alu_res = bus_a;
            default:        alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        en_w     = 1'b0;
        bus_w    = '0;
        addr_w   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_EXEC;
                    end else if ((op == OP_SHL || op == OP_SHR) &&
                                 bus_b[3:0] != 4'd0) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_EXEC: begin
                busy = 1'b1;
                if (op_q == OP_MUL) begin
                    mul_step = 1'b1;
                    if (mul_last) begin
                        state_d = ST_WRITE;
                    end
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
                if (op_valid_q) begin
                    en_w   = 1'b1;
                    bus_w  = fin_res;
                    addr_w = dest_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fin_res = (op_q == OP_MUL) ? mul_lo : res_q;
    assign fin_c   = (op_q == OP_MUL) ? mul_hi_nz : carry_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            dest_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op;
                dest_q  <= dest;
                res_q   <= alu_res;
                carry_q <= alu_c;
                cnt_q   <= bus_b[3:0];
            end else if (state_q == ST_EXEC && op_q != OP_MUL) begin
                cnt_q <= cnt_q - 4'd1;
                if (op_q == OP_SHL) begin
                    {carry_q, res_q} <= {res_q, 1'b0};
                end else begin
                    {res_q, carry_q} <= {1'b0, res_q};
                end
            end
            if (state_q == ST_WRITE && op_valid_q) begin
                flag_z <= (fin_res == '0);
                flag_c <= fin_c;
                flag_n <= fin_res[WIDTH-1];
            end
        end
    end

    shift_add_mul u_mul (
        .clk        (clk),
        .reset      (reset),
        .load       (mul_load),
        .step       (mul_step),
        .a          (bus_a),
        .b          (bus_b),
        .product_lo (mul_lo),
        .hi_nonzero (mul_hi_nz),
        .last       (mul_last)
    );

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [2:0]  dest;
    logic [15:0] bus_a;
    logic [15:0] bus_b;
    logic        busy;
    logic        done;
    logic [15:0] bus_w;
    logic [2:0]  addr_w;
    logic        en_w;
    logic        flag_z;
    logic        flag_c;
    logic        flag_n;

    int checks = 0;
    int errors = 0;
    logic exp_z = 1'b0;
    logic exp_c = 1'b0;
    logic exp_n = 1'b0;

    alu_exec dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .dest   (dest),
        .bus_a  (bus_a),
        .bus_b  (bus_b),
        .busy   (busy),
        .done   (done),
        .bus_w  (bus_w),
        .addr_w (addr_w),
        .en_w   (en_w),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_n (flag_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o,
                                  input logic [15:0] a,
                                  input logic [15:0] b,
                                  output bit v,
                                  output logic [15:0] r,
                                  output logic c,
                                  output int lat);
        logic [31:0] w;
        int k;
        k = int'(b[3:0]);
        v = 1'b1;
        r = '0;
        c = 1'b0;
        lat = 1;
        case (o)
            4'd0: begin
                w = 32'(a) + 32'(b);
                r = w[15:0];
                c = w[16];
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: r = b;
            4'd7: begin
                w = 32'(a) << k;
                r = w[15:0];
                c = (k > 0) ? w[16] : 1'b0;
                lat = k + 1;
            end
            4'd8: begin
                r = a >> k;
                c = (k > 0) ? a[k-1] : 1'b0;
                lat = k + 1;
            end
            4'd9: begin
                w = 32'(a) * 32'(b);
                r = w[15:0];
                c = |w[31:16];
                lat = 17;
            end
            default: v = 1'b0;
        endcase
    endfunction

    // Issue one op and watch it to completion; optionally pulse start mid-op.
    task automatic run_op(input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] d,
                          input bit poke);
        bit v;
        logic [15:0] r;
        logic c;
        int lat;
        int done_cyc;
        int en_cyc;
        int en_cnt;
        model(o, a, b, v, r, c, lat);
        @(negedge clk);
        op = o; bus_a = a; bus_b = b; dest = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0;
        en_cyc = 0;
        en_cnt = 0;
        for (int n = 1; n <= lat + 3; n++) begin
            @(negedge clk);
            if (poke && n == 3) begin
                op = 4'd0; bus_a = 16'h1111; bus_b = 16'h2222;
                dest = 3'd7; start = 1'b1;
            end
            if (poke && n == 4) start = 1'b0;
            if (done && done_cyc == 0) done_cyc = n;
            if (en_w) begin
                en_cnt++;
                if (en_cyc == 0) en_cyc = n;
                chk("bus_w", bus_w, r);
                chk("addr_w", addr_w, d);
            end
            if (n == lat) chk("busy_in_write", busy, 1);
            if (n == lat + 1) begin
                if (v) begin
                    exp_z = (r == 16'd0);
                    exp_c = c;
                    exp_n = r[15];
                end
                chk("busy_after", busy, 0);
                chk("bus_w_idle", bus_w, 0);
                chk("flags", {flag_z, flag_c, flag_n}, {exp_z, exp_c, exp_n});
            end
        end
        chk("done_cycle", done_cyc, lat);
        chk("en_count", en_cnt, v ? 1 : 0);
        if (v) chk("en_cycle", en_cyc, lat);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {busy, done, en_w, bus_w, addr_w, flag_z, flag_c, flag_n}, 0);
    endtask

    initial begin
        int stray;
        reset = 1'b1; start = 1'b0; op = '0; dest = '0;
        bus_a = '0; bus_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset_idle");

        run_op(4'd0, 16'd625, 16'd626, 3'd3, 1'b0);
        run_op(4'd1, 16'd12, 16'd625, 3'd2, 1'b0);
        run_op(4'd9, 16'd625, 16'd12, 3'd4, 1'b0);
        run_op(4'd9, 16'd625, 16'd626, 3'd5, 1'b0);
        run_op(4'd7, 16'h8001, 16'd1, 3'd1, 1'b0);
        run_op(4'd8, 16'hB234, 16'h0010, 3'd6, 1'b0);
        run_op(4'd8, 16'hB235, 16'h000F, 3'd6, 1'b0);
        run_op(4'd12, 16'h0000, 16'h0000, 3'd7, 1'b0);
        run_op(4'd9, 16'd300, 16'd7, 3'd2, 1'b1);

        // Reset in cycle 5 of a multiply.
        @(negedge clk);
        op = 4'd9; bus_a = 16'd1234; bus_b = 16'd567; dest = 3'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        exp_z = 1'b0; exp_c = 1'b0; exp_n = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (en_w || done || busy) stray++;
        end
        chk("no_write_after_reset", stray, 0);
        run_op(4'd0, 16'hFFFF, 16'h0001, 3'd1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 12)), 16'($urandom),
                   16'($urandom), 3'($urandom_range(0, 7)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
